bp_cce_inv_sequencer: RTL and testbench
=======================================

# bp_cce_inv_sequencer

Downstream consumer of the CCE directory's way-group read result. It latches the sharers vectors (`hits`, `ways`, `coh_states`) once the directory reports them valid. It then serializes one invalidation command per sharing LCE, skipping the requesting LCE, onto the LCE command path. It counts invalidation acks and signals completion to the CCE instruction pipeline, replacing the per-LCE invalidate loop that microcode would otherwise run.

## Interface
- `num_lce_p`, 8, total LCEs tracked (I$, D$ and A$ interleaved as in the directory).
- `lce_id_width_p`, `BSG_SAFE_CLOG2(num_lce_p)`, LCE id width.
- `lce_assoc_width_p`, 3, way index width.
- `paddr_width_p`, 40, physical address width.
- `clk_i`  in  1  clock.
- `reset_n_i`  in  1  asynchronous, active-low reset.
- `start_v_i`  in  1  start request.
- `ready_o`  out  1  sequencer idle and able to accept `start_v_i`.
- `sharers_v_i`  in  1  directory sharers outputs valid.
- `sharers_hits_i`  in  `num_lce_p`  per-LCE hit.
- `sharers_ways_i`  in  `num_lce_p`x`lce_assoc_width_p`  per-LCE way.
- `sharers_coh_states_i`  in  `num_lce_p`x`$bits(bp_coh_states_e)`  per-LCE state.
- `req_lce_i`  in  `lce_id_width_p`  requesting LCE, excluded from the sweep.
- `addr_i`  in  `paddr_width_p`  block address to invalidate.
- `inv_v_o`  out  1  invalidate command valid.
- `inv_lce_o`  out  `lce_id_width_p`  target LCE.
- `inv_way_o`  out  `lce_assoc_width_p`  target way.
- `inv_addr_o`  out  `paddr_width_p`  target address.
- `inv_yumi_i`  in  1  command consumed; legal only while `inv_v_o` is high.
- `ack_v_i`  in  1  one invalidation ack received.
- `done_o`  out  1  one-cycle completion pulse.
- `inv_count_o`  out  `BSG_WIDTH(num_lce_p)`  number of invalidations sent; valid with `done_o`.

## Operation
- **Reset.** Asynchronous assertion forces the following, regardless of any operation in flight:
  - state IDLE, `ready_o`=1;
  - mask, pending counter and `inv_count_o` cleared to 0;
  - `inv_v_o`=0 and `done_o`=0;
  - `inv_lce_o`, `inv_way_o` and `inv_addr_o` driven to 0.
- **States:** IDLE, SEND, WAIT, DONE.
- **IDLE.**
  - Start is accepted when `start_v_i & sharers_v_i`.
  - On accept, the block latches:
    - `mask[i] = hits[i] & (coh_states[i] != e_COH_I) & (i != req_lce_i)`;
    - the ways vector;
    - the address.
  - Next state: SEND if the mask is nonzero, else DONE.
  - `start_v_i` while `sharers_v_i`=0 is ignored.
- **SEND.**
  - `inv_v_o`=1; the target is the lowest set mask bit (fixed priority, index 0 first).
  - `inv_lce_o`, `inv_way_o` and `inv_addr_o` hold stable until `inv_yumi_i`.
  - On yumi:
    - clear that mask bit;
    - increment `inv_count_o`;
    - increment the pending counter.
  - After the yumi that clears the last bit, go to WAIT.
- **WAIT.** Go to DONE when pending==0, counting an ack arriving in the same cycle.
- **DONE.** `done_o`=1 for exactly one cycle, then IDLE. `inv_count_o` holds its value until the next accept.
- **Pending counter.**
  - Width `BSG_WIDTH(num_lce_p)`.
  - +1 on yumi, −1 on `ack_v_i`; both in the same cycle leaves it unchanged.
  - Acks may arrive during SEND.
- **Invariants (simulation assertions):**
  - an ack while pending==0 is an error and is ignored;
  - yumi without `inv_v_o` is an error.

## Timing
- Start to first `inv_v_o`: 1 cycle.
- Throughput: one command per cycle while `inv_yumi_i` is held high.
- Empty mask: start accepted in cycle N, `done_o` in N+1, `inv_count_o`=0.
- Final yumi in cycle N with all acks already received: WAIT in N+1 (pending 0), `done_o` in N+2.
- Last ack in cycle M during WAIT: `done_o` in M+1.
- `ready_o` is high only in IDLE, including the cycle after DONE.

## Configuration
- **`BP_CCE_INV_ACK_TRACK_EN` defined:** behaviour as above; the pending counter exists and WAIT gates DONE.
- **Not defined:**
  - the pending counter and WAIT are removed and `ack_v_i` is ignored;
  - the last yumi goes directly to DONE, so `done_o` comes 1 cycle after the final yumi;
  - intended for configurations where the CCE counts acks in microcode.

## Test plan
- **Basic sweep with requester excluded.** Hits=0b1011_0010, all states S, `req_lce_i`=1, ways all 2, yumi held high.
  - Commands to LCE 4, 5, 7 on consecutive cycles.
  - 3 acks → `done_o` with `inv_count_o`=3.
- **Empty sweep.** Hits=0b0000_0010, `req_lce_i`=1 → no `inv_v_o`; `done_o` one cycle after start; count 0.
- **Backpressure and skipping I entries.**
  - Hits=0xFF with states I on the odd LCEs; yumi toggles every other cycle.
  - Required: LCE 0, 2, 4, 6 in order, with outputs stable while un-yumi'd.
- **Early acks.**
  - Acks arrive in the same cycle as each yumi: pending stays 0, `done_o` 2 cycles after the last yumi.
  - With the macro undefined: `done_o` 1 cycle after the last yumi.
- **Reset mid-operation.**
  - Drop `reset_n_i` asynchronously mid-SEND with 2 commands outstanding.
  - Required: `inv_v_o`, `done_o` and count drop immediately, `ready_o`=1.
  - A subsequent sweep behaves normally.
- **Start gating.** `start_v_i` with `sharers_v_i`=0 → stays IDLE; no output activity.

Source files
------------

// File: rtl/bp_cce_inv_sequencer_if.sv
// Command/handshake bundle between the CCE and the invalidation sequencer.
// Signal names keep the sequencer-side _i/_o direction view.
interface bp_cce_inv_sequencer_if #(
  parameter int num_lce_p         = 8,
  parameter int lce_assoc_width_p = 3,
  parameter int paddr_width_p     = 40,
  parameter int coh_width_p       = 3,
  parameter int lce_id_width_p    = (num_lce_p == 1) ? 1 : $clog2(num_lce_p),
  parameter int count_width_p     = $clog2(num_lce_p + 1)
);
  logic                                        start_v_i;
  logic                                        ready_o;
  logic                                        sharers_v_i;
  logic [num_lce_p-1:0]                        sharers_hits_i;
  logic [num_lce_p-1:0][lce_assoc_width_p-1:0] sharers_ways_i;
  logic [num_lce_p-1:0][coh_width_p-1:0]       sharers_coh_states_i;
  logic [lce_id_width_p-1:0]                   req_lce_i;
  logic [paddr_width_p-1:0]                    addr_i;
  logic                                        inv_v_o;
  logic [lce_id_width_p-1:0]                   inv_lce_o;
  logic [lce_assoc_width_p-1:0]                inv_way_o;
  logic [paddr_width_p-1:0]                    inv_addr_o;
  logic                                        inv_yumi_i;
  logic                                        ack_v_i;
  logic                                        done_o;
  logic [count_width_p-1:0]                    inv_count_o;

  modport master (
    output start_v_i, sharers_v_i, sharers_hits_i, sharers_ways_i, sharers_coh_states_i,
           req_lce_i, addr_i, inv_yumi_i, ack_v_i,
    input  ready_o, inv_v_o, inv_lce_o, inv_way_o, inv_addr_o, done_o, inv_count_o
  );

  modport slave (
    input  start_v_i, sharers_v_i, sharers_hits_i, sharers_ways_i, sharers_coh_states_i,
           req_lce_i, addr_i, inv_yumi_i, ack_v_i,
    output ready_o, inv_v_o, inv_lce_o, inv_way_o, inv_addr_o, done_o, inv_count_o
  );
endinterface

// File: rtl/bp_cce_inv_sequencer.sv
// Serializes one invalidation per sharing LCE (requester excluded) and signals completion.
// Define BP_CCE_INV_ACK_TRACK_EN to count acks and hold completion until all have returned.
module bp_cce_inv_sequencer #(
  parameter int num_lce_p         = 8,
  parameter int lce_assoc_width_p = 3,
  parameter int paddr_width_p     = 40
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  bp_cce_inv_sequencer_if.slave seq
);
  localparam int lce_id_width_lp = (num_lce_p == 1) ? 1 : $clog2(num_lce_p);
  localparam int cnt_width_lp    = $clog2(num_lce_p + 1);

  typedef enum logic [2:0] {
    e_COH_I = 3'b000, e_COH_S = 3'b001, e_COH_E = 3'b010,
    e_COH_F = 3'b011, e_COH_M = 3'b110, e_COH_O = 3'b111
  } bp_coh_states_e;

`ifdef BP_CCE_INV_ACK_TRACK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd3} state_e;
`endif

  // Fixed priority: index 0 wins, so scan downwards and keep the last hit.
  function automatic logic [lce_id_width_lp-1:0] lowest_set(input logic [num_lce_p-1:0] m);
    lowest_set = '0;
    for (int i = num_lce_p - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = lce_id_width_lp'(i);
    end
  endfunction

  state_e                                      state_r;
  logic                                        ready_r;
  logic                                        inv_v_r;
  logic                                        done_r;
  logic [num_lce_p-1:0]                        mask_r;
  logic [num_lce_p-1:0][lce_assoc_width_p-1:0] ways_r;
  logic [lce_id_width_lp-1:0]                  inv_lce_r;
  logic [lce_assoc_width_p-1:0]                inv_way_r;
  logic [paddr_width_p-1:0]                    inv_addr_r;
  logic [cnt_width_lp-1:0]                     count_r;

  logic [num_lce_p-1:0]       start_mask_s;
  logic [num_lce_p-1:0]       mask_clr_s;
  logic [lce_id_width_lp-1:0] first_lce_s;
  logic [lce_id_width_lp-1:0] next_lce_s;
  logic                       yumi_fire_s;

  // Sharer mask at accept, and the mask/target left after the current command is consumed.
  always_comb begin
    start_mask_s = '0;
    for (int i = 0; i < num_lce_p; i++) begin
      start_mask_s[i] = seq.sharers_hits_i[i]
                      & (seq.sharers_coh_states_i[i] != e_COH_I)
                      & (lce_id_width_lp'(i) != seq.req_lce_i);
    end
    first_lce_s = lowest_set(start_mask_s);
    yumi_fire_s = (state_r == SEND) & inv_v_r & seq.inv_yumi_i;
    mask_clr_s  = mask_r & ~(num_lce_p'(1'b1) << inv_lce_r);
    next_lce_s  = lowest_set(mask_clr_s);
  end

`ifdef BP_CCE_INV_ACK_TRACK_EN
  logic [cnt_width_lp-1:0] pending_r;
  logic [cnt_width_lp-1:0] pending_next_s;
  logic                    ack_fire_s;

  // An ack landing with a yumi cancels it even at zero; a lone ack at zero is dropped.
  always_comb begin
    ack_fire_s = seq.ack_v_i & ((pending_r != '0) | yumi_fire_s);
    if (yumi_fire_s & ~ack_fire_s) begin
      pending_next_s = pending_r + cnt_width_lp'(1'b1);
    end else if (ack_fire_s & ~yumi_fire_s) begin
      pending_next_s = pending_r - cnt_width_lp'(1'b1);
    end else begin
      pending_next_s = pending_r;
    end
  end
`endif

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= IDLE;
      ready_r    <= 1'b1;
      inv_v_r    <= 1'b0;
      done_r     <= 1'b0;
      mask_r     <= '0;
      ways_r     <= '0;
      inv_lce_r  <= '0;
      inv_way_r  <= '0;
      inv_addr_r <= '0;
      count_r    <= '0;
`ifdef BP_CCE_INV_ACK_TRACK_EN
      pending_r  <= '0;
`endif
    end else begin
      done_r <= 1'b0;
`ifdef BP_CCE_INV_ACK_TRACK_EN
      pending_r <= pending_next_s;
`endif
      case (state_r)
        IDLE: begin
          if (seq.start_v_i & seq.sharers_v_i) begin
            mask_r     <= start_mask_s;
            ways_r     <= seq.sharers_ways_i;
            inv_addr_r <= seq.addr_i;
            count_r    <= '0;
            ready_r    <= 1'b0;
            if (start_mask_s != '0) begin
              state_r   <= SEND;
              inv_v_r   <= 1'b1;
              inv_lce_r <= first_lce_s;
              inv_way_r <= seq.sharers_ways_i[first_lce_s];
            end else begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        SEND: begin
          if (yumi_fire_s) begin
            mask_r  <= mask_clr_s;
            count_r <= count_r + cnt_width_lp'(1'b1);
            if (mask_clr_s != '0) begin
              inv_lce_r <= next_lce_s;
              inv_way_r <= ways_r[next_lce_s];
            end else begin
              inv_v_r <= 1'b0;
`ifdef BP_CCE_INV_ACK_TRACK_EN
              state_r <= WAIT;
`else
              state_r <= DONE;
              done_r  <= 1'b1;
`endif
            end
          end else begin
            state_r <= SEND;
          end
        end
`ifdef BP_CCE_INV_ACK_TRACK_EN
        WAIT: begin
          if (pending_next_s == '0) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            state_r <= WAIT;
          end
        end
`endif
        DONE: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          ready_r <= 1'b1;
          inv_v_r <= 1'b0;
        end
      endcase
    end
  end

  assign seq.ready_o     = ready_r;
  assign seq.inv_v_o     = inv_v_r;
  assign seq.inv_lce_o   = inv_lce_r;
  assign seq.inv_way_o   = inv_way_r;
  assign seq.inv_addr_o  = inv_addr_r;
  assign seq.done_o      = done_r;
  assign seq.inv_count_o = count_r;

`ifdef BP_CCE_INV_ACK_TRACK_EN
  bp_cce_inv_sequencer_chk #(.cnt_width_p(cnt_width_lp), .ack_track_p(1'b1)) chk (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .inv_v(inv_v_r), .inv_yumi(seq.inv_yumi_i),
    .ack_v(seq.ack_v_i), .yumi_fire(yumi_fire_s), .pending(pending_r)
  );
`else
  bp_cce_inv_sequencer_chk #(.cnt_width_p(cnt_width_lp), .ack_track_p(1'b0)) chk (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .inv_v(inv_v_r), .inv_yumi(seq.inv_yumi_i),
    .ack_v(seq.ack_v_i), .yumi_fire(yumi_fire_s), .pending('0)
  );
`endif
endmodule

// Protocol invariants on the command and ack handshakes.
module bp_cce_inv_sequencer_chk #(
  parameter int cnt_width_p = 4,
  parameter bit ack_track_p = 1'b1
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  input logic                   inv_v,
  input logic                   inv_yumi,
  input logic                   ack_v,
  input logic                   yumi_fire,
  input logic [cnt_width_p-1:0] pending
);
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    inv_yumi |-> inv_v) else $error("inv_yumi_i asserted without inv_v_o");

  ack_needs_pending: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    (ack_v & ack_track_p) |-> ((pending != '0) | yumi_fire))
    else $error("ack_v_i with no invalidation pending");
endmodule

// File: tb/tb_bp_cce_inv_sequencer.sv
// Directed bench for bp_cce_inv_sequencer: scoreboard of expected commands plus timing checks.
module tb_bp_cce_inv_sequencer;
  typedef struct packed {
    logic [2:0]  lce;
    logic [2:0]  way;
    logic [39:0] addr;
  } cmd_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail = 0;
  cmd_t exp_q[$];

  bp_cce_inv_sequencer_if ifc ();

  bp_cce_inv_sequencer dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .seq       (ifc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ifc.start_v_i            = 1'b0;
    ifc.sharers_v_i          = 1'b0;
    ifc.sharers_hits_i       = 8'h00;
    ifc.sharers_ways_i       = 24'h0;
    ifc.sharers_coh_states_i = 24'h0;
    ifc.req_lce_i            = 3'd0;
    ifc.addr_i               = 40'h0;
    ifc.inv_yumi_i           = 1'b0;
    ifc.ack_v_i              = 1'b0;
  endtask

  // ack_mode: 0 = acks after all commands, 1 = ack with each yumi, 2 = ack the cycle after each yumi
  task automatic sweep(input string name, input logic [7:0] hits, input logic [23:0] states,
                       input logic [2:0] req, input logic [23:0] ways, input logic [39:0] addr,
                       input bit toggle, input int ack_mode);
    cmd_t c;
    int exp_cnt, cyc, last_yumi, last_ack, owed, d_exp;
    bit tog, yumi_now, ack_now, yumi_prev, prev_hold, seen_done;
    logic [2:0]  p_lce, p_way;
    logic [39:0] p_addr;
    exp_q.delete();
    for (int i = 0; i < 8; i++)
      if (hits[i] && states[3*i +: 3] != 3'b000 && i != int'(req))
        exp_q.push_back('{lce: 3'(i), way: ways[3*i +: 3], addr: addr});
    exp_cnt = exp_q.size();
    last_yumi = 0; last_ack = 0; owed = 0; d_exp = 0;
    tog = 1'b0; yumi_prev = 1'b0; prev_hold = 1'b0; seen_done = 1'b0;
    p_lce = 3'd0; p_way = 3'd0; p_addr = 40'h0;

    @(negedge clk);
    check({name, "/ready_before"}, 64'(ifc.ready_o), 64'd1);
    ifc.start_v_i = 1'b1; ifc.sharers_v_i = 1'b1;
    ifc.sharers_hits_i = hits; ifc.sharers_coh_states_i = states;
    ifc.sharers_ways_i = ways; ifc.req_lce_i = req; ifc.addr_i = addr;
    @(negedge clk);
    idle_inputs();
    cyc = 1;
    while (!seen_done && cyc <= 60) begin
      check({name, "/inv_v"}, 64'(ifc.inv_v_o), 64'(exp_q.size() != 0));
      if (prev_hold) begin
        check({name, "/hold_lce"}, 64'(ifc.inv_lce_o), 64'(p_lce));
        check({name, "/hold_way"}, 64'(ifc.inv_way_o), 64'(p_way));
        check({name, "/hold_addr"}, 64'(ifc.inv_addr_o), 64'(p_addr));
      end
      yumi_now = 1'b0;
      ack_now  = 1'b0;
      if (ifc.done_o) begin
        seen_done = 1'b1;
`ifdef BP_CCE_INV_ACK_TRACK_EN
        d_exp = (exp_cnt == 0) ? 1 : ((last_ack + 1 > last_yumi + 2) ? last_ack + 1 : last_yumi + 2);
`else
        d_exp = (exp_cnt == 0) ? 1 : last_yumi + 1;
`endif
        check({name, "/done_cycle"}, 64'(cyc), 64'(d_exp));
        check({name, "/count"}, 64'(ifc.inv_count_o), 64'(exp_cnt));
        check({name, "/all_sent"}, 64'(exp_q.size()), 64'd0);
      end else begin
        yumi_now = ifc.inv_v_o && (!toggle || tog);
        tog = !tog;
        if (yumi_now && exp_q.size() != 0) begin
          c = exp_q.pop_front();
          check({name, "/lce"}, 64'(ifc.inv_lce_o), 64'(c.lce));
          check({name, "/way"}, 64'(ifc.inv_way_o), 64'(c.way));
          check({name, "/addr"}, 64'(ifc.inv_addr_o), 64'(c.addr));
          last_yumi = cyc;
          owed++;
        end
        case (ack_mode)
          1:       ack_now = yumi_now;
          2:       ack_now = yumi_prev;
          default: ack_now = (exp_q.size() == 0) && !yumi_now && (owed > 0);
        endcase
        if (ack_now) begin
          owed--;
          last_ack = cyc;
        end
      end
      prev_hold = ifc.inv_v_o && !yumi_now;
      p_lce = ifc.inv_lce_o; p_way = ifc.inv_way_o; p_addr = ifc.inv_addr_o;
      yumi_prev = yumi_now;
      ifc.inv_yumi_i = yumi_now;
      ifc.ack_v_i = ack_now;
      @(negedge clk);
      cyc++;
    end
    ifc.inv_yumi_i = 1'b0;
    ifc.ack_v_i = 1'b0;
    check({name, "/done_seen"}, 64'(seen_done), 64'd1);
    check({name, "/done_pulse"}, 64'(ifc.done_o), 64'd0);
    check({name, "/ready_after"}, 64'(ifc.ready_o), 64'd1);
    check({name, "/count_hold"}, 64'(ifc.inv_count_o), 64'(exp_cnt));
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    check("rst/ready", 64'(ifc.ready_o), 64'd1);
    check("rst/inv_v", 64'(ifc.inv_v_o), 64'd0);
    check("rst/done", 64'(ifc.done_o), 64'd0);
    check("rst/count", 64'(ifc.inv_count_o), 64'd0);
    check("rst/target", 64'({ifc.inv_lce_o, ifc.inv_way_o}), 64'd0);
    check("rst/addr", 64'(ifc.inv_addr_o), 64'd0);
    reset_n = 1'b1;

    // Basic sweep: LCEs 4,5,7 with requester 1 excluded, all S, ways 2.
    sweep("basic", 8'b1011_0010, {8{3'b001}}, 3'd1, {8{3'b010}}, 40'h12_3456_7800, 1'b0, 0);
    // Only the requester hits: nothing sent.
    sweep("empty", 8'b0000_0010, {8{3'b001}}, 3'd1, {8{3'b010}}, 40'h00_0000_0040, 1'b0, 0);
    // Odd LCEs invalid, backpressure on yumi, acks trail each yumi.
    sweep("backpressure", 8'hFF, {3'b000, 3'b110, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000, 3'b011},
          3'd3, {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}, 40'hAB_CDEF_0000, 1'b1, 2);
    // Acks coincide with each yumi.
    sweep("early_ack", 8'h5B, {8{3'b110}}, 3'd0, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0},
          40'hFF_0000_1000, 1'b0, 1);

    // Start without valid sharers must be ignored.
    @(negedge clk);
    ifc.start_v_i = 1'b1; ifc.sharers_v_i = 1'b0; ifc.sharers_hits_i = 8'hFF;
    ifc.sharers_coh_states_i = {8{3'b001}};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("gate/ready", 64'(ifc.ready_o), 64'd1);
      check("gate/inv_v", 64'(ifc.inv_v_o), 64'd0);
      check("gate/done", 64'(ifc.done_o), 64'd0);
    end
    idle_inputs();

    // Reset in the middle of SEND with two commands consumed.
    @(negedge clk);
    ifc.start_v_i = 1'b1; ifc.sharers_v_i = 1'b1; ifc.sharers_hits_i = 8'hFF;
    ifc.sharers_coh_states_i = {8{3'b001}}; ifc.req_lce_i = 3'd0;
    ifc.sharers_ways_i = {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}; ifc.addr_i = 40'h55_5555_5500;
    @(negedge clk);
    idle_inputs();
    ifc.inv_yumi_i = ifc.inv_v_o;
    @(negedge clk);
    ifc.inv_yumi_i = ifc.inv_v_o;
    @(negedge clk);
    ifc.inv_yumi_i = 1'b0;
    check("midrst/pre_inv_v", 64'(ifc.inv_v_o), 64'd1);
    check("midrst/pre_count", 64'(ifc.inv_count_o), 64'd2);
    check("midrst/pre_lce", 64'(ifc.inv_lce_o), 64'd3);
    #2 reset_n = 1'b0;
    #1;
    check("midrst/inv_v", 64'(ifc.inv_v_o), 64'd0);
    check("midrst/done", 64'(ifc.done_o), 64'd0);
    check("midrst/count", 64'(ifc.inv_count_o), 64'd0);
    check("midrst/ready", 64'(ifc.ready_o), 64'd1);
    check("midrst/target", 64'({ifc.inv_lce_o, ifc.inv_way_o}), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    sweep("post_reset", 8'h81, {8{3'b001}}, 3'd7, {8{3'b101}}, 40'h01_0203_0400, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
